// File: rtl/wt_mem_req_arbiter.sv
// Round-robin merge of I$/D$ requests into one registered memory request channel,
// with return routing and per-source outstanding-transaction throttling.
module wt_mem_req_arbiter #(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned RtrnWidth      = 128,
    parameter int unsigned TidWidth       = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ic_req_i,
    output logic                 ic_ack_o,
    input  logic [AddrWidth-1:0] ic_addr_i,
    input  logic [TidWidth-1:0]  ic_tid_i,
    input  logic                 ic_nc_i,
    input  logic                 dc_req_i,
    output logic                 dc_ack_o,
    input  logic [AddrWidth-1:0] dc_addr_i,
    input  logic [DataWidth-1:0] dc_wdata_i,
    input  logic                 dc_we_i,
    input  logic [2:0]           dc_size_i,
    input  logic [TidWidth-1:0]  dc_tid_i,
    input  logic                 dc_nc_i,
    output logic                 mem_req_o,
    input  logic                 mem_ack_i,
    output logic                 mem_src_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic                 mem_we_o,
    output logic [2:0]           mem_size_o,
    output logic [TidWidth-1:0]  mem_tid_o,
    output logic                 mem_nc_o,
    input  logic                 rtrn_vld_i,
    input  logic                 rtrn_src_i,
    input  logic [TidWidth-1:0]  rtrn_tid_i,
    input  logic [RtrnWidth-1:0] rtrn_data_i,
    output logic                 ic_rtrn_vld_o,
    output logic                 dc_rtrn_vld_o,
    output logic [TidWidth-1:0]  rtrn_tid_o,
    output logic [RtrnWidth-1:0] rtrn_data_o,
    output logic                 idle_o,
    output logic                 err_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  r_rr_dc;
    logic [CntWidth-1:0]   r_cnt_ic;
    logic [CntWidth-1:0]   r_cnt_dc;
    logic                  r_err;
    logic                  r_src;
    logic [AddrWidth-1:0]  r_addr;
    logic [DataWidth-1:0]  r_wdata;
    logic                  r_we;
    logic [2:0]            r_size;
    logic [TidWidth-1:0]   r_tid;
    logic                  r_nc;

    logic w_elig_ic;
    logic w_elig_dc;
    logic w_slot_free;
    logic w_gnt_ic;
    logic w_gnt_dc;
    logic w_ret_ic;
    logic w_ret_dc;

    // A new grant may only be issued when the output register is empty or draining now.
    always_comb begin
        w_elig_ic   = ic_req_i && (r_cnt_ic < CntMax);
        w_elig_dc   = dc_req_i && (r_cnt_dc < CntMax);
        w_slot_free = (r_state == S_IDLE) || mem_ack_i;
        w_gnt_ic    = w_slot_free && w_elig_ic && (!w_elig_dc || !r_rr_dc);
        w_gnt_dc    = w_slot_free && w_elig_dc && (!w_elig_ic || r_rr_dc);
        w_ret_ic    = rtrn_vld_i && !rtrn_src_i;
        w_ret_dc    = rtrn_vld_i && rtrn_src_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_gnt_ic || w_gnt_dc) w_state_nxt = S_HOLD;
            S_HOLD: if (mem_ack_i && !w_gnt_ic && !w_gnt_dc) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ic_ack_o      = w_gnt_ic;
        dc_ack_o      = w_gnt_dc;
        mem_req_o     = (r_state == S_HOLD);
        ic_rtrn_vld_o = w_ret_ic;
        dc_rtrn_vld_o = w_ret_dc;
        rtrn_tid_o    = rtrn_tid_i;
        rtrn_data_o   = rtrn_data_i;
        idle_o        = (r_state == S_IDLE) && (r_cnt_ic == '0) && (r_cnt_dc == '0);
        err_o         = r_err;
        mem_src_o     = r_src;
        mem_addr_o    = r_addr;
        mem_wdata_o   = r_wdata;
        mem_we_o      = r_we;
        mem_size_o    = r_size;
        mem_tid_o     = r_tid;
        mem_nc_o      = r_nc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_src   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_size  <= '0;
            r_tid   <= '0;
            r_nc    <= 1'b0;
            r_rr_dc <= 1'b0;
        end else if (w_gnt_ic) begin
            r_src   <= 1'b0;
            r_addr  <= ic_addr_i;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_size  <= 3'b111;
            r_tid   <= ic_tid_i;
            r_nc    <= ic_nc_i;
            r_rr_dc <= 1'b1;
        end else if (w_gnt_dc) begin
            r_src   <= 1'b1;
            r_addr  <= dc_addr_i;
            r_wdata <= dc_wdata_i;
            r_we    <= dc_we_i;
            r_size  <= dc_size_i;
            r_tid   <= dc_tid_i;
            r_nc    <= dc_nc_i;
            r_rr_dc <= 1'b0;
        end
    end

    // Same-cycle grant and return cancel out; an unmatched return saturates at zero.
    function automatic logic [CntWidth-1:0] f_cnt_nxt(
        input logic [CntWidth-1:0] cnt,
        input logic                inc,
        input logic                dec
    );
        if (inc && !dec) return cnt + CntOne;
        if (dec && !inc && (cnt != '0)) return cnt - CntOne;
        return cnt;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt_ic <= '0;
            r_cnt_dc <= '0;
            r_err    <= 1'b0;
        end else begin
            r_cnt_ic <= f_cnt_nxt(r_cnt_ic, w_gnt_ic, w_ret_ic);
            r_cnt_dc <= f_cnt_nxt(r_cnt_dc, w_gnt_dc, w_ret_dc);
            if ((w_ret_ic && (r_cnt_ic == '0)) || (w_ret_dc && (r_cnt_dc == '0))) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Self-checking bench for wt_mem_req_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_wt_mem_req_arbiter;

    localparam int MAXO = 4;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         ic_req_i = 1'b0;
    logic         ic_ack_o;
    logic [63:0]  ic_addr_i = '0;
    logic [1:0]   ic_tid_i = '0;
    logic         ic_nc_i = 1'b0;
    logic         dc_req_i = 1'b0;
    logic         dc_ack_o;
    logic [63:0]  dc_addr_i = '0;
    logic [63:0]  dc_wdata_i = '0;
    logic         dc_we_i = 1'b0;
    logic [2:0]   dc_size_i = '0;
    logic [1:0]   dc_tid_i = '0;
    logic         dc_nc_i = 1'b0;
    logic         mem_req_o;
    logic         mem_ack_i = 1'b0;
    logic         mem_src_o;
    logic [63:0]  mem_addr_o;
    logic [63:0]  mem_wdata_o;
    logic         mem_we_o;
    logic [2:0]   mem_size_o;
    logic [1:0]   mem_tid_o;
    logic         mem_nc_o;
    logic         rtrn_vld_i = 1'b0;
    logic         rtrn_src_i = 1'b0;
    logic [1:0]   rtrn_tid_i = '0;
    logic [127:0] rtrn_data_i = '0;
    logic         ic_rtrn_vld_o;
    logic         dc_rtrn_vld_o;
    logic [1:0]   rtrn_tid_o;
    logic [127:0] rtrn_data_o;
    logic         idle_o;
    logic         err_o;

    int checks = 0;
    int errors = 0;

    wt_mem_req_arbiter #(
        .AddrWidth(64), .DataWidth(64), .RtrnWidth(128),
        .TidWidth(2), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_req_i(ic_req_i), .ic_ack_o(ic_ack_o), .ic_addr_i(ic_addr_i),
        .ic_tid_i(ic_tid_i), .ic_nc_i(ic_nc_i),
        .dc_req_i(dc_req_i), .dc_ack_o(dc_ack_o), .dc_addr_i(dc_addr_i),
        .dc_wdata_i(dc_wdata_i), .dc_we_i(dc_we_i), .dc_size_i(dc_size_i),
        .dc_tid_i(dc_tid_i), .dc_nc_i(dc_nc_i),
        .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_src_o(mem_src_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
        .mem_size_o(mem_size_o), .mem_tid_o(mem_tid_o), .mem_nc_o(mem_nc_o),
        .rtrn_vld_i(rtrn_vld_i), .rtrn_src_i(rtrn_src_i), .rtrn_tid_i(rtrn_tid_i),
        .rtrn_data_i(rtrn_data_i), .ic_rtrn_vld_o(ic_rtrn_vld_o),
        .dc_rtrn_vld_o(dc_rtrn_vld_o), .rtrn_tid_o(rtrn_tid_o),
        .rtrn_data_o(rtrn_data_o), .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: outstanding counts, whether a request sits in the
    // output register, who is favoured on a tie, and the held payload.
    int           m_cnt[2];
    bit           m_hold;
    bit           m_pref;
    bit           m_err;
    logic [137:0] m_pay;

    function automatic logic [137:0] pay_of(input bit src);
        if (!src) return {1'b0, ic_addr_i, 64'h0, 1'b0, 3'b111, ic_tid_i, ic_nc_i};
        return {1'b1, dc_addr_i, dc_wdata_i, dc_we_i, dc_size_i, dc_tid_i, dc_nc_i};
    endfunction

    function automatic void predict(output bit gi, output bit gd);
        bit ei, ed;
        ei = ic_req_i && m_cnt[0] < MAXO;
        ed = dc_req_i && m_cnt[1] < MAXO;
        gi = 0;
        gd = 0;
        if (!m_hold || mem_ack_i) begin
            if (ei && ed) begin
                gi = !m_pref;
                gd = m_pref;
            end else begin
                gi = ei;
                gd = ed;
            end
        end
    endfunction

    function automatic void model_reset();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_hold = 0;
        m_pref = 0;
        m_err = 0;
        m_pay = '0;
    endfunction

    function automatic void model_tick();
        bit g[2];
        bit r[2];
        predict(g[0], g[1]);
        r[0] = rtrn_vld_i && !rtrn_src_i;
        r[1] = rtrn_vld_i && rtrn_src_i;
        if (g[0] || g[1]) begin
            m_pay  = pay_of(g[1]);
            m_hold = 1;
            m_pref = g[0];
        end else if (mem_ack_i) begin
            m_hold = 0;
        end
        for (int s = 0; s < 2; s++) begin
            if (r[s] && m_cnt[s] == 0) m_err = 1;
            if (g[s] && !r[s]) m_cnt[s]++;
            else if (r[s] && !g[s] && m_cnt[s] > 0) m_cnt[s]--;
        end
    endfunction

    task automatic next_cyc();
        model_tick();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        ic_req_i = 0;
        dc_req_i = 0;
        mem_ack_i = 0;
        rtrn_vld_i = 0;
        rtrn_src_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        clear_inputs();
        rst_i = 1;
        #1;
        model_reset();
        @(negedge clk_i);
        rst_i = 0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        clear_inputs();
        rst_i = 1;
        #1;
        model_reset();
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_req: got %b want 0", mem_req_o);
        end
        checks++;
        if (idle_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_err: got idle=%b err=%b want 1/0", idle_o, err_o);
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, mem_tid_o} !== '0) begin
            errors++;
            $display("FAIL reset_payload: got addr=%h want 0", mem_addr_o);
        end
        @(negedge clk_i);
        rst_i = 0;
    endtask

    task automatic test_single();
        do_reset();
        ic_req_i = 1;
        ic_addr_i = 64'h8000_0000;
        ic_tid_i = 0;
        ic_nc_i = 0;
        #1;
        checks++;
        if (ic_ack_o !== 1'b1 || dc_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: got ic=%b dc=%b want 1/0", ic_ack_o, dc_ack_o);
        end
        next_cyc();
        ic_req_i = 0;
        for (int c = 1; c <= 3; c++) begin
            mem_ack_i = (c == 2);
            #1;
            checks++;
            if (mem_req_o !== (c <= 2) || ic_ack_o !== 1'b0) begin
                errors++;
                $display("FAIL single_req_c%0d: got req=%b ack=%b want %b/0",
                         c, mem_req_o, ic_ack_o, c <= 2);
            end
            if (c == 1) begin
                checks++;
                if (mem_src_o !== 1'b0 || mem_addr_o !== 64'h8000_0000 ||
                    mem_size_o !== 3'b111 || mem_we_o !== 1'b0 || idle_o !== 1'b0) begin
                    errors++;
                    $display("FAIL single_payload: got src=%b addr=%h size=%b idle=%b want 0/80000000/111/0",
                             mem_src_o, mem_addr_o, mem_size_o, idle_o);
                end
            end
            next_cyc();
        end
        mem_ack_i = 0;
        rtrn_vld_i = 1;
        rtrn_src_i = 0;
        next_cyc();
        rtrn_vld_i = 0;
        #1;
        checks++;
        if (idle_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got idle=%b err=%b want 1/0", idle_o, err_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        ic_req_i = 1;
        dc_req_i = 1;
        mem_ack_i = 1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (ic_ack_o !== (k % 2 == 0) || dc_ack_o !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL rr_grant_%0d: got ic=%b dc=%b want %b/%b",
                         k, ic_ack_o, dc_ack_o, k % 2 == 0, k % 2 == 1);
            end
            if (k > 0) begin
                checks++;
                if (mem_req_o !== 1'b1 || mem_src_o !== ((k - 1) % 2 == 1)) begin
                    errors++;
                    $display("FAIL rr_mem_%0d: got req=%b src=%b want 1/%b",
                             k, mem_req_o, mem_src_o, (k - 1) % 2 == 1);
                end
            end
            next_cyc();
        end
        clear_inputs();
        next_cyc();
    endtask

    task automatic test_throttle();
        do_reset();
        dc_req_i = 1;
        dc_we_i = 0;
        mem_ack_i = 1;
        for (int k = 0; k < 8; k++) begin
            rtrn_vld_i = (k == 6);
            rtrn_src_i = 1;
            #1;
            checks++;
            if (dc_ack_o !== (k < 4 || k == 7)) begin
                errors++;
                $display("FAIL throttle_%0d: got dc_ack=%b want %b", k, dc_ack_o, k < 4 || k == 7);
            end
            next_cyc();
        end
        clear_inputs();
        mem_ack_i = 1;
        next_cyc();
    endtask

    task automatic test_return_route();
        mem_ack_i = 0;
        rtrn_vld_i = 1;
        rtrn_src_i = 1;
        rtrn_tid_i = 2;
        rtrn_data_i = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
        #1;
        checks++;
        if (dc_rtrn_vld_o !== 1'b1 || ic_rtrn_vld_o !== 1'b0 || rtrn_tid_o !== 2'd2 ||
            rtrn_data_o !== 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL rtrn_route: got dc=%b ic=%b tid=%0d data=%h want 1/0/2/deadbeef...",
                     dc_rtrn_vld_o, ic_rtrn_vld_o, rtrn_tid_o, rtrn_data_o);
        end
        next_cyc();
        rtrn_vld_i = 0;
    endtask

    task automatic test_same_cycle_and_err();
        do_reset();
        dc_req_i = 1;
        mem_ack_i = 1;
        for (int k = 0; k < 6; k++) begin
            rtrn_vld_i = (k == 2);
            rtrn_src_i = 1;
            #1;
            checks++;
            if (dc_ack_o !== (k < 5)) begin
                errors++;
                $display("FAIL same_cycle_%0d: got dc_ack=%b want %b", k, dc_ack_o, k < 5);
            end
            next_cyc();
        end
        dc_req_i = 0;
        rtrn_vld_i = 1;
        rtrn_src_i = 0;
        #1;
        checks++;
        if (ic_rtrn_vld_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_fwd: got ic_rtrn=%b err=%b want 1/0", ic_rtrn_vld_o, err_o);
        end
        next_cyc();
        rtrn_vld_i = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (err_o !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky_%0d: got %b want 1", k, err_o);
            end
            next_cyc();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ic_req_i = 1;
        next_cyc();
        ic_req_i = 0;
        #1;
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_hold: got mem_req=%b want 1", mem_req_o);
        end
        rst_i = 1;
        #1;
        model_reset();
        checks++;
        if (mem_req_o !== 1'b0 || idle_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got req=%b idle=%b err=%b want 0/1/0", mem_req_o, idle_o, err_o);
        end
        @(negedge clk_i);
        rst_i = 0;
        ic_req_i = 1;
        dc_req_i = 1;
        #1;
        checks++;
        if (ic_ack_o !== 1'b1 || dc_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_first_grant: got ic=%b dc=%b want 1/0", ic_ack_o, dc_ack_o);
        end
        next_cyc();
        clear_inputs();
        rtrn_vld_i = 1;
        rtrn_src_i = 1;
        next_cyc();
        rtrn_vld_i = 0;
        #1;
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_stale_rtrn: got err=%b want 1", err_o);
        end
    endtask

    task automatic test_random();
        bit gi, gd, last_gi, last_gd;
        bit want_idle;
        logic [137:0] got_pay;
        do_reset();
        last_gi = 0;
        last_gd = 0;
        for (int c = 0; c < 3000; c++) begin
            if (last_gi) ic_req_i = 0;
            if (last_gd) dc_req_i = 0;
            if (!ic_req_i && $urandom_range(2) == 0) begin
                ic_req_i = 1;
                ic_addr_i = {$urandom, $urandom};
                ic_tid_i = 2'($urandom);
                ic_nc_i = 1'($urandom);
            end
            if (!dc_req_i && $urandom_range(2) == 0) begin
                dc_req_i = 1;
                dc_addr_i = {$urandom, $urandom};
                dc_wdata_i = {$urandom, $urandom};
                dc_we_i = 1'($urandom);
                dc_size_i = 3'($urandom);
                dc_tid_i = 2'($urandom);
                dc_nc_i = 1'($urandom);
            end
            mem_ack_i = ($urandom_range(3) != 0);
            rtrn_src_i = 1'($urandom);
            rtrn_vld_i = ($urandom_range(2) == 0);
            if (m_cnt[rtrn_src_i] == 0 && $urandom_range(60) != 0) rtrn_vld_i = 0;
            rtrn_tid_i = 2'($urandom);
            rtrn_data_i = {$urandom, $urandom, $urandom, $urandom};
            #1;
            predict(gi, gd);
            checks++;
            if (ic_ack_o !== gi || dc_ack_o !== gd) begin
                errors++;
                $display("FAIL rnd_ack_c%0d: got ic=%b dc=%b want %b/%b", c, ic_ack_o, dc_ack_o, gi, gd);
            end
            checks++;
            if (mem_req_o !== m_hold) begin
                errors++;
                $display("FAIL rnd_req_c%0d: got %b want %b", c, mem_req_o, m_hold);
            end
            if (m_hold) begin
                got_pay = {mem_src_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_size_o, mem_tid_o, mem_nc_o};
                checks++;
                if (got_pay !== m_pay) begin
                    errors++;
                    $display("FAIL rnd_payload_c%0d: got %h want %h", c, got_pay, m_pay);
                end
            end
            checks++;
            if (ic_rtrn_vld_o !== (rtrn_vld_i && !rtrn_src_i) ||
                dc_rtrn_vld_o !== (rtrn_vld_i && rtrn_src_i) ||
                rtrn_tid_o !== rtrn_tid_i || rtrn_data_o !== rtrn_data_i) begin
                errors++;
                $display("FAIL rnd_rtrn_c%0d: got ic=%b dc=%b tid=%0d", c, ic_rtrn_vld_o, dc_rtrn_vld_o, rtrn_tid_o);
            end
            want_idle = !m_hold && m_cnt[0] == 0 && m_cnt[1] == 0;
            checks++;
            if (idle_o !== want_idle || err_o !== m_err) begin
                errors++;
                $display("FAIL rnd_status_c%0d: got idle=%b err=%b want %b/%b", c, idle_o, err_o, want_idle, m_err);
            end
            last_gi = gi;
            last_gd = gd;
            next_cyc();
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_throttle();
        test_return_route();
        test_same_cycle_and_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
